// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider with glitch-free start/stop and common sync
module clk_div_prog #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*DIV_W-1:0] cur_div
);
    typedef enum logic {IDLE, RUN} state_e;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d, cur_div_q, cur_div_d, pdiv_q, pdiv_d, cfg_c, nxt_div;
        logic [DIV_W:0]   half;
        logic             pend_q, pend_d, tick_q, tick_d, clk_out_q, clk_out_d, bnd, start, stop;
        always_comb begin
            cfg_c     = div_cfg[g*DIV_W +: DIV_W] < DIV_W'(2) ? DIV_W'(2) : div_cfg[g*DIV_W +: DIV_W];
            nxt_div   = pend_q ? pdiv_q : cur_div_q;
            bnd       = cnt_q == cur_div_q - DIV_W'(1);
            start     = en[g] && (state_q == IDLE || sync || bnd);
            stop      = state_q == RUN && !en[g] && (sync || bnd);
            state_d   = state_q;
            cnt_d     = cnt_q + DIV_W'(1);
            cur_div_d = cur_div_q;
            pend_d    = pend_q;
            pdiv_d    = pdiv_q;
            tick_d    = 1'b0;
            if (start) begin
                state_d   = RUN;
                cnt_d     = '0;
                cur_div_d = nxt_div;
                pend_d    = 1'b0;
                tick_d    = 1'b1;
            end else if (stop || state_q == IDLE) begin
                state_d   = IDLE;
                cnt_d     = '0;
                cur_div_d = cfg_load[g] ? cfg_c : nxt_div;
                pend_d    = 1'b0;
            end
            // a running channel only stages the new divisor until its next period start
            if (cfg_load[g] && state_d == RUN) begin
                pend_d = 1'b1;
                pdiv_d = cfg_c;
            end
            half      = ({1'b0, cur_div_d} + (DIV_W+1)'(1)) >> 1;
            clk_out_d = state_d == RUN && {1'b0, cnt_d} < half;
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                cur_div_q <= DIV_W'(DEFAULT_DIV);
                pdiv_q    <= DIV_W'(DEFAULT_DIV);
                pend_q    <= 1'b0;
                tick_q    <= 1'b0;
                clk_out_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                cur_div_q <= cur_div_d;
                pdiv_q    <= pdiv_d;
                pend_q    <= pend_d;
                tick_q    <= tick_d;
                clk_out_q <= clk_out_d;
            end
        end
        assign clk_out[g]                  = clk_out_q;
        assign tick[g]                     = tick_q;
        assign busy[g]                     = state_q == RUN;
        assign cur_div[g*DIV_W +: DIV_W]   = cur_div_q;
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench comparing every cycle against a behavioural divider model
module tb_clk_div_prog;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int DEF = 2;
    logic            clk = 1'b0;
    logic            reset, sync;
    logic [NC-1:0]   en, cfg_load, clk_out, tick, busy;
    logic [NC*DW-1:0] div_cfg, cur_div;
    typedef struct {
        logic [NC-1:0]    co, tk, bz;
        logic [NC*DW-1:0] cd;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int m_run[NC], m_cnt[NC], m_div[NC], m_pend[NC], m_pdiv[NC], m_tick[NC];
    clk_div_prog #(.NUM_CH(NC), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load), .div_cfg(div_cfg),
        .sync(sync), .clk_out(clk_out), .tick(tick), .busy(busy), .cur_div(cur_div)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_step();
        exp_t e;
        for (int i = 0; i < NC; i++) begin
            int c;
            c = int'(div_cfg[i*DW +: DW]);
            if (c < 2) c = 2;
            if (reset) begin
                m_run[i] = 0; m_cnt[i] = 0; m_div[i] = DEF; m_pend[i] = 0; m_tick[i] = 0;
            end else begin
                if (!m_run[i] || sync || m_cnt[i] == m_div[i] - 1) begin
                    if (m_pend[i] != 0) m_div[i] = m_pdiv[i];
                    m_pend[i] = 0;
                    m_run[i]  = en[i] ? 1 : 0;
                    m_tick[i] = en[i] ? 1 : 0;
                    m_cnt[i]  = 0;
                end else begin
                    m_cnt[i]++;
                    m_tick[i] = 0;
                end
                if (cfg_load[i]) begin
                    if (m_run[i] != 0) begin
                        m_pend[i] = 1;
                        m_pdiv[i] = c;
                    end else m_div[i] = c;
                end
            end
            e.co[i] = m_run[i] != 0 && 2 * m_cnt[i] < m_div[i];
            e.tk[i] = m_tick[i] != 0;
            e.bz[i] = m_run[i] != 0;
            e.cd[i*DW +: DW] = DW'(m_div[i]);
        end
        q.push_back(e);
    endtask
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            model_step();
            @(posedge clk);
            #1;
            e = q.pop_front();
            chk("clk_out", 32'(clk_out), 32'(e.co));
            chk("tick", 32'(tick), 32'(e.tk));
            chk("busy", 32'(busy), 32'(e.bz));
            chk("cur_div", cur_div, e.cd);
        end
    endtask
    task automatic load(input int ch, input int v);
        div_cfg[ch*DW +: DW] = DW'(v);
        cfg_load[ch] = 1'b1;
        step(1);
        cfg_load = '0;
    endtask
    initial begin
        reset = 1'b1; sync = 1'b0; en = '0; cfg_load = '0; div_cfg = '0;
        step(2);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        en[0] = 1'b1;
        step(8);
        load(1, 5);
        step(2);
        chk("idle_load", 32'(cur_div[15:8]), 5);
        en[1] = 1'b1;
        step(12);
        load(2, 4);
        en[2] = 1'b1;
        step(2);
        load(2, 7);
        step(18);
        load(3, 6);
        en[3] = 1'b1;
        step(3);
        en[3] = 1'b0;
        step(8);
        chk("stop_busy", 32'(busy[3]), 0);
        en[3] = 1'b1;
        step(8);
        load(0, 3);
        load(1, 4);
        load(2, 8);
        step(13);
        en[3] = 1'b0;
        step(10);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("sync_tick", 32'(tick), 32'h7);
        chk("sync_clk", 32'(clk_out), 32'h7);
        step(5);
        load(3, 0);
        step(1);
        chk("clamp0", 32'(cur_div[31:24]), 2);
        load(3, 1);
        step(1);
        chk("clamp1", 32'(cur_div[31:24]), 2);
        load(0, 9);
        step(12);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_mid", 32'(busy), 0);
        chk("rst_div", 32'(cur_div[7:0]), DEF);
        step(3);
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 7) == 0) ? NC'($urandom) : en;
            cfg_load = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '0;
            for (int i = 0; i < NC; i++) div_cfg[i*DW +: DW] = DW'($urandom_range(0, 12));
            sync     = $urandom_range(0, 15) == 0;
            reset    = $urandom_range(0, 99) == 0;
            step(1);
        end
        reset = 1'b0; sync = 1'b0; cfg_load = '0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
